mdio_responder: RTL and testbench

PHY-side station-management responder: the far end of the MDIO controller on the shared `MDIO_io` line. It samples one MDIO bit per `clk` cycle and decodes ST/OP/PHYAD/REGAD. On an address match it either serves a read, driving turnaround and 16 data bits, or captures a write and pulses a register-write strobe. It sits between the MDIO pad and a 32×16 management register file.

---
 rtl/mdio_pkg.sv | 42 ++++
 rtl/mdio_regfile.sv | 20 ++
 rtl/mdio_responder.sv | 181 ++++++++++++++++++
 tb/tb_mdio_responder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared MDIO definitions: frame field widths, opcodes, FSM state encoding.
// Used by both the station controller and the PHY-side responder.
package mdio_pkg;

  localparam int ST_W    = 2;
  localparam int OP_W    = 2;
  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int TA_W    = 2;
  localparam int DATA_W  = 16;
  localparam int CNT_W   = 5;

  localparam int REG_DEPTH  = 1 << REGAD_W;
  localparam int IGNORE_LEN = 18;

  localparam logic [ST_W-1:0] ST_PATTERN = 2'b01;
  localparam logic [OP_W-1:0] OP_READ    = 2'b10;
  localparam logic [OP_W-1:0] OP_WRITE   = 2'b01;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ST1,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_RDATA,
    S_WDATA,
    S_IGNORE
  } mdio_state_e;

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [PHYAD_W-1:0] phyad;
    logic [REGAD_W-1:0] regad;
  } mdio_hdr_t;

  function automatic logic op_valid(input logic [OP_W-1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/mdio_regfile.sv
// 32x16 management register array: synchronous write, registered read on re.
module mdio_regfile
  import mdio_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [REGAD_W-1:0] addr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic               re,
  output logic [DATA_W-1:0]  rdata
);

  logic [DATA_W-1:0] mem [REG_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mdio_responder.sv
// PHY-side MDIO responder: decodes ST/OP/PHYAD/REGAD one bit per clk, serves
// reads by driving TA2 + D0..D15, captures writes and pulses a write strobe.
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [PHYAD_W-1:0] PHY_ADDR = 5'b11011
) (
  input  logic               clk,
  input  logic               rst,
  inout  wire                MDIO_io,
  output logic [REGAD_W-1:0] reg_addr_o,
  output logic               reg_re_o,
  input  logic [DATA_W-1:0]  reg_rdata_i,
  output logic               reg_we_o,
  output logic [DATA_W-1:0]  reg_wdata_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               frame_err_o
);

  mdio_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  mdio_hdr_t          hdr_q, hdr_d;
  logic [DATA_W-1:0]  sh_q, sh_d;
  logic               drv_en_q, drv_en_d;
  logic [REGAD_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               re_q, re_d, we_q, we_d, done_q, done_d, err_q, err_d;
  logic               mdio_bit;

  // Pull-up semantics: anything that is not a solid 0 (Z, X, 1) reads as 1.
  assign mdio_bit = (MDIO_io !== 1'b0);

  // sh_q[0] is the line value while driving; it is cleared during TA so TA2 is 0.
  assign MDIO_io = drv_en_q ? sh_q[0] : 1'bz;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hdr_d    = hdr_q;
    sh_d     = sh_q;
    drv_en_d = drv_en_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    re_d     = 1'b0;
    we_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mdio_bit == ST_PATTERN[1]) state_d = S_ST1;
      end
      S_ST1: begin
        if (mdio_bit == ST_PATTERN[0]) begin
          state_d = S_OP;
          cnt_d   = CNT_W'(OP_W - 1);
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_OP: begin
        hdr_d.op = {hdr_q.op[OP_W-2:0], mdio_bit};
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (op_valid(hdr_d.op)) begin
          state_d = S_PHYAD;
          cnt_d   = CNT_W'(PHYAD_W - 1);
        end else begin
          err_d   = 1'b1;
          state_d = S_IGNORE;
          cnt_d   = CNT_W'(IGNORE_LEN - 1);
        end
      end
      S_PHYAD: begin
        hdr_d.phyad = {hdr_q.phyad[PHYAD_W-2:0], mdio_bit};
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_REGAD;
          cnt_d   = CNT_W'(REGAD_W - 1);
        end
      end
      S_REGAD: begin
        hdr_d.regad = {hdr_q.regad[REGAD_W-2:0], mdio_bit};
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          addr_d = hdr_d.regad;
          if (hdr_d.phyad != PHY_ADDR) begin
            state_d = S_IGNORE;
            cnt_d   = CNT_W'(IGNORE_LEN - 1);
          end else begin
            state_d = S_TA;
            cnt_d   = CNT_W'(TA_W - 1);
            re_d    = (hdr_q.op == OP_READ);
          end
        end
      end
      S_TA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          sh_d  = '0;
          if (hdr_q.op == OP_READ) drv_en_d = 1'b1;
        end else begin
          cnt_d = CNT_W'(DATA_W - 1);
          // Register-file data is valid during TA2, so it is loaded at its end.
          if (hdr_q.op == OP_READ) begin
            state_d = S_RDATA;
            sh_d    = reg_rdata_i;
          end else begin
            state_d = S_WDATA;
          end
        end
      end
      S_RDATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          sh_d  = {1'b0, sh_q[DATA_W-1:1]};
        end else begin
          drv_en_d = 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_WDATA: begin
        sh_d = {mdio_bit, sh_q[DATA_W-1:1]};
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          wdata_d = sh_d;
          we_d    = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_IGNORE: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else             state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hdr_q    <= '0;
      sh_q     <= '0;
      drv_en_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hdr_q    <= hdr_d;
      sh_q     <= sh_d;
      drv_en_q <= drv_en_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      re_q     <= re_d;
      we_q     <= we_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign reg_addr_o  = addr_q;
  assign reg_re_o    = re_q;
  assign reg_we_o    = we_q;
  assign reg_wdata_o = wdata_q;
  assign done_o      = done_q;
  assign frame_err_o = err_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder + mdio_regfile: a frame-level model plans the line
// and every expected output per cycle; each scenario plays its plan.
module tb_mdio_responder;
  import mdio_pkg::*;

  localparam logic [4:0] PHY  = 5'h1B;
  localparam int         MAXC = 1100;

  typedef struct packed {
    logic        line;
    logic        re;
    logic        we;
    logic        done;
    logic        err;
    logic        busy;
    logic [4:0]  addr;
    logic [15:0] wdata;
  } obs_t;

  logic        clk;
  logic        rst;
  logic        m_en, m_bit;
  wire         mdio;
  logic [4:0]  reg_addr;
  logic        reg_re, reg_we, busy, done_w, ferr;
  logic [15:0] reg_rdata, reg_wdata;

  pullup (mdio);
  assign mdio = m_en ? m_bit : 1'bz;

  mdio_responder #(.PHY_ADDR(PHY)) dut (
    .clk(clk), .rst(rst), .MDIO_io(mdio),
    .reg_addr_o(reg_addr), .reg_re_o(reg_re), .reg_rdata_i(reg_rdata),
    .reg_we_o(reg_we), .reg_wdata_o(reg_wdata),
    .busy_o(busy), .done_o(done_w), .frame_err_o(ferr)
  );

  mdio_regfile u_rf (
    .clk(clk), .we(reg_we), .addr(reg_addr), .wdata(reg_wdata),
    .re(reg_re), .rdata(reg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // plan: master drive, reset and expected observation per cycle
  logic        s_en  [MAXC];
  logic        s_bit [MAXC];
  logic        s_rst [MAXC];
  obs_t        exp_q [MAXC];
  int          plan_len;
  logic [15:0] mem_m [32];
  logic [4:0]  cur_addr;
  logic [15:0] cur_wdata;
  int          n_checks, n_pass;
  int          s_re, s_we, s_done, s_err, x_re, x_we, x_done, x_err, d_first, d_last;

  function automatic obs_t idle_obs(input logic [4:0] a, input logic [15:0] w);
    obs_t o;
    o = '0;
    o.line = 1'b1; o.addr = a; o.wdata = w;
    return o;
  endfunction

  task automatic plan_clear();
    for (int c = 0; c < MAXC; c++) begin
      s_en[c] = 1'b0; s_bit[c] = 1'b0; s_rst[c] = 1'b0;
      exp_q[c] = idle_obs(cur_addr, cur_wdata);
    end
    plan_len = 0;
  endtask

  task automatic drive(input int c, input logic b);
    s_en[c] = 1'b1; s_bit[c] = b; exp_q[c].line = b;
  endtask

  // Cycle c of a frame: master drives bit c before edge E(c); observation c is the state after E(c-1).
  task automatic add_frame(input int base, input logic [1:0] st, input logic [1:0] op,
                           input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] wd,
                           input int abort, output int next);
    logic [15:0] rd;
    drive(base, st[1]);
    drive(base + 1, st[0]);
    if (st != ST_PATTERN) begin
      exp_q[base + 1].busy = 1'b1;
      exp_q[base + 2].err  = 1'b1;
      next = base + 2;
    end else begin
      drive(base + 2, op[1]);
      drive(base + 3, op[0]);
      if (op != OP_READ && op != OP_WRITE) begin
        for (int c = base + 1; c <= base + 3 + 18; c++) exp_q[c].busy = 1'b1;
        exp_q[base + 4].err = 1'b1;
        next = base + 3 + 18 + 1;
      end else begin
        for (int i = 0; i < 5; i++) drive(base + 4 + i, phy[4 - i]);
        for (int i = 0; i < 5; i++) drive(base + 9 + i, ra[4 - i]);
        if (op == OP_WRITE) begin
          drive(base + 14, 1'b1);
          drive(base + 15, 1'b0);
          for (int k = 0; k < 16; k++) drive(base + 16 + k, wd[k]);
        end
        for (int c = base + 1; c <= base + 31; c++) exp_q[c].busy = 1'b1;
        for (int c = base + 14; c < MAXC; c++) exp_q[c].addr = ra;
        cur_addr = ra;
        if (phy == PHY && op == OP_READ) begin
          rd = mem_m[ra];
          exp_q[base + 14].re   = 1'b1;
          exp_q[base + 15].line = 1'b0;
          for (int k = 0; k < 16; k++) exp_q[base + 16 + k].line = rd[k];
          exp_q[base + 32].done = 1'b1;
        end
        if (phy == PHY && op == OP_WRITE && abort < 0) begin
          exp_q[base + 32].we   = 1'b1;
          exp_q[base + 32].done = 1'b1;
          for (int c = base + 32; c < MAXC; c++) exp_q[c].wdata = wd;
          mem_m[ra] = wd;
          cur_wdata = wd;
        end
        next = base + 32;
      end
    end
    if (abort >= 0) begin
      s_rst[base + abort] = 1'b1;
      for (int c = base + abort; c < MAXC; c++) begin
        if (s_en[c]) begin s_en[c] = 1'b0; exp_q[c].line = 1'b1; end
        if (c > base + abort) exp_q[c] = idle_obs(5'd0, 16'd0);
      end
      cur_addr = 5'd0; cur_wdata = 16'd0;
      next = base + abort + 1;
    end
    plan_len = next + 2;
  endtask

  task automatic play(input string name);
    obs_t got;
    s_re = 0; s_we = 0; s_done = 0; s_err = 0;
    x_re = 0; x_we = 0; x_done = 0; x_err = 0;
    d_first = -1; d_last = -1;
    for (int c = 0; c < plan_len; c++) begin
      if (exp_q[c].re)   x_re++;
      if (exp_q[c].we)   x_we++;
      if (exp_q[c].done) x_done++;
      if (exp_q[c].err)  x_err++;
    end
    for (int c = 0; c < plan_len; c++) begin
      @(negedge clk);
      m_en = s_en[c]; m_bit = s_bit[c]; rst = s_rst[c];
      #1;
      got = {mdio, reg_re, reg_we, done_w, ferr, busy, reg_addr, reg_wdata};
      if (reg_re) s_re++;
      if (reg_we) s_we++;
      if (ferr)   s_err++;
      if (done_w) begin
        s_done++;
        if (d_first < 0) d_first = c;
        d_last = c;
      end
      n_checks++;
      if (got !== exp_q[c])
        $display("FAIL %s cycle %0d: got line/re/we/done/err/busy/addr/wdata=%h expected %h",
                 name, c, got, exp_q[c]);
      else n_pass++;
    end
    m_en = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_en = 1'b0; m_bit = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({reg_re, reg_we, done_w, ferr, busy} !== 5'b0)
      $display("FAIL reset_strobes: got %b expected 00000", {reg_re, reg_we, done_w, ferr, busy});
    else n_pass++;
    n_checks++;
    if (reg_addr !== 5'd0) $display("FAIL reset_addr: got %h expected 00", reg_addr);
    else n_pass++;
    n_checks++;
    if (reg_wdata !== 16'd0) $display("FAIL reset_wdata: got %h expected 0000", reg_wdata);
    else n_pass++;
    n_checks++;
    if (mdio !== 1'b1) $display("FAIL reset_line: got %b expected 1 (released)", mdio);
    else n_pass++;
    rst = 1'b0;
    cur_addr = 5'd0; cur_wdata = 16'd0;
  endtask

  task automatic test_fill();
    int b;
    logic [15:0] d;
    plan_clear(); b = 0;
    for (int r = 0; r < 32; r++) begin
      d = (r == 27) ? 16'hCC33 : 16'($urandom);
      add_frame(b, ST_PATTERN, OP_WRITE, PHY, 5'(r), d, -1, b);
    end
    play("fill_writes");
    n_checks++;
    if (s_we !== 32) $display("FAIL fill_we_count: got %0d expected 32", s_we);
    else n_pass++;
  endtask

  task automatic test_read();
    int b;
    plan_clear();
    add_frame(0, ST_PATTERN, OP_READ, PHY, 5'h1B, 16'h0, -1, b);
    play("read_cc33");
    n_checks++;
    if (s_re !== 1 || s_done !== 1)
      $display("FAIL read_pulses: got re=%0d done=%0d expected 1 1", s_re, s_done);
    else n_pass++;
  endtask

  task automatic test_write_readback();
    int b;
    plan_clear();
    add_frame(0, ST_PATTERN, OP_WRITE, PHY, 5'h03, 16'hA5F0, -1, b);
    add_frame(b, ST_PATTERN, OP_READ, PHY, 5'h03, 16'h0, -1, b);
    play("write_readback");
    n_checks++;
    if (s_we !== 1 || s_done !== 2)
      $display("FAIL write_readback_pulses: got we=%0d done=%0d expected 1 2", s_we, s_done);
    else n_pass++;
  endtask

  task automatic test_mismatch();
    int b;
    plan_clear();
    add_frame(0, ST_PATTERN, OP_READ, 5'h01, 5'h1B, 16'h0, -1, b);
    add_frame(b, ST_PATTERN, OP_READ, PHY, 5'h1B, 16'h0, -1, b);
    play("phy_mismatch");
    n_checks++;
    if (s_re !== 1 || s_done !== 1)
      $display("FAIL mismatch_pulses: got re=%0d done=%0d expected 1 1", s_re, s_done);
    else n_pass++;
  endtask

  task automatic test_frame_errors();
    int b;
    plan_clear();
    add_frame(0, 2'b00, OP_READ, PHY, 5'h00, 16'h0, -1, b);
    add_frame(b, ST_PATTERN, 2'b11, PHY, 5'h00, 16'h0, -1, b);
    add_frame(b, ST_PATTERN, OP_READ, PHY, 5'h03, 16'h0, -1, b);
    play("frame_errors");
    n_checks++;
    if (s_err !== 2 || s_done !== 1)
      $display("FAIL frame_err_pulses: got err=%0d done=%0d expected 2 1", s_err, s_done);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int b;
    logic [15:0] old5;
    old5 = mem_m[5];
    plan_clear();
    add_frame(0, ST_PATTERN, OP_READ, PHY, 5'h1B, 16'h0, 20, b);
    add_frame(b, ST_PATTERN, OP_WRITE, PHY, 5'h05, ~old5, 25, b);
    add_frame(b, ST_PATTERN, OP_READ, PHY, 5'h05, 16'h0, -1, b);
    play("reset_midframe");
    n_checks++;
    if (s_we !== 0 || s_done !== 1)
      $display("FAIL abort_pulses: got we=%0d done=%0d expected 0 1", s_we, s_done);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int b;
    plan_clear();
    add_frame(0, ST_PATTERN, OP_READ, PHY, 5'h1B, 16'h0, -1, b);
    add_frame(b, ST_PATTERN, OP_READ, PHY, 5'h03, 16'h0, -1, b);
    play("back_to_back");
    n_checks++;
    if (s_done !== 2 || d_last - d_first !== 32)
      $display("FAIL b2b_done_spacing: got count=%0d spacing=%0d expected 2 32",
               s_done, d_last - d_first);
    else n_pass++;
  endtask

  task automatic test_random();
    int b, kind;
    logic [4:0]  phy, ra;
    logic [15:0] wd;
    plan_clear(); b = 0;
    for (int i = 0; i < 20; i++) begin
      kind = int'($urandom_range(0, 9));
      ra = 5'($urandom); wd = 16'($urandom); phy = PHY;
      case (kind)
        0: add_frame(b, 2'b00, OP_READ, phy, ra, wd, -1, b);
        1: add_frame(b, ST_PATTERN, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, phy, ra, wd, -1, b);
        2: begin
          phy = 5'($urandom);
          if (phy == PHY) phy ^= 5'h01;
          add_frame(b, ST_PATTERN, ($urandom_range(0, 1) != 0) ? OP_READ : OP_WRITE, phy, ra, wd, -1, b);
        end
        3, 4, 5, 6: add_frame(b, ST_PATTERN, OP_READ, phy, ra, wd, -1, b);
        default:    add_frame(b, ST_PATTERN, OP_WRITE, phy, ra, wd, -1, b);
      endcase
      b += int'($urandom_range(0, 2));
      plan_len = b + 2;
    end
    play("random");
    n_checks++;
    if (s_done !== x_done || s_err !== x_err || s_re !== x_re || s_we !== x_we)
      $display("FAIL random_pulse_counts: got re/we/done/err=%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
               s_re, s_we, s_done, s_err, x_re, x_we, x_done, x_err);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; m_en = 1'b0; m_bit = 1'b1;
    test_reset();
    test_fill();
    test_read();
    test_write_readback();
    test_mismatch();
    test_frame_errors();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
